// File: rtl/matrix_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_accel_pkg
//  Description : Shared defaults, feeder state encoding and the lane-slice
//                helper for the matrix accelerator datapath.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_accel_pkg;

  localparam int N_DEF  = 4;  // systolic array dimension
  localparam int DW_DEF = 8;  // element width in bits

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } feeder_state_e;

  // Lane i of a packed N*DW bus occupies [i*DW +: DW].
  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_row_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tile_row_buffer
//  Description : NxN element register file. One row-wide write port; N
//                combinational read lanes producing the diagonally skewed
//                view of the tile for skew step t.
//  Ports       : clk        - clock
//                wr_en_i    - write row wr_row_i with wr_data_i
//                wr_row_i   - row index
//                wr_data_i  - row data, element c at [c*DW +: DW]
//                rd_t_i     - skew step
//                rd_data_o  - lane i = buf[i][t-i], 0 outside the window
//                rd_vld_o   - per-lane in-window mask
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_row_buffer
  import matrix_accel_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int DW = DW_DEF,
  localparam int SW = $clog2(2 * N - 1),
  localparam int RW = $clog2(N)
) (
  input  logic            clk,
  input  logic            wr_en_i,
  input  logic [RW-1:0]   wr_row_i,
  input  logic [N*DW-1:0] wr_data_i,
  input  logic [SW-1:0]   rd_t_i,
  output logic [N*DW-1:0] rd_data_o,
  output logic [N-1:0]    rd_vld_o
);

  // Contents are don't-care after reset, so no reset on the storage.
  logic [N-1:0][DW-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_row_i] <= wr_data_i;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, DW);
    logic [SW-1:0] col;
    logic          in_win;

    // When t < i the subtraction wraps to at least 2^SW-(N-1) >= N, so a
    // single upper-bound compare covers both edges of the window.
    assign col    = rd_t_i - SW'(i);
    assign in_win = (col < SW'(N));

    assign rd_vld_o[i]             = in_win;
    assign rd_data_o[LSB +: DW]    = in_win ? mem_q[i][col[RW-1:0]] : '0;
  end

endmodule
`default_nettype wire

// File: rtl/matrix_tile_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_tile_feeder
//  Description : Collects one NxN tile row by row over a valid/ready
//                handshake, then drains it into the systolic array with
//                diagonal skew (lane i = row i delayed i cycles).
//                Load and drain alternate on a single tile buffer.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                in_valid_i       - upstream row valid
//                in_ready_o       - row accepted this cycle when valid
//                in_row_i         - row data, element c at [c*DW +: DW]
//                array_en_i       - array advancing; 0 stalls the drain
//                out_valid_o      - output beat valid
//                out_data_o       - lane i at [i*DW +: DW]
//                out_lane_vld_o   - per-lane element valid
//                out_first_o      - first skew step of a tile
//                out_last_o       - final skew step of a tile
//                tile_done_o      - pulse coincident with out_last_o
//                busy_o           - draining
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_tile_feeder
  import matrix_accel_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N*DW-1:0] in_row_i,
  input  logic            array_en_i,
  output logic            out_valid_o,
  output logic [N*DW-1:0] out_data_o,
  output logic [N-1:0]    out_lane_vld_o,
  output logic            out_first_o,
  output logic            out_last_o,
  output logic            tile_done_o,
  output logic            busy_o
);

  localparam int            SW       = $clog2(2 * N - 1);
  localparam int            RW       = $clog2(N);
  localparam logic [SW-1:0] T_LAST   = SW'(2 * N - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);

  feeder_state_e   state_q, state_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic [SW-1:0]   skew_cnt_q, skew_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [N*DW-1:0] out_data_q, out_data_d;
  logic [N-1:0]    out_vld_q, out_vld_d;
  logic            out_first_q, out_first_d;
  logic            out_last_q, out_last_d;

  logic            accept;
  logic [N*DW-1:0] rd_data;
  logic [N-1:0]    rd_vld;

  // The FSM is already back in LOAD while the out_last beat is on the
  // outputs; holding ready low for that one cycle keeps the handshake
  // closed for every visible drain beat.
  assign in_ready_o = (state_q == ST_LOAD) && !out_last_q;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state_q == ST_DRAIN);

  tile_row_buffer #(
    .N  (N),
    .DW (DW)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (accept),
    .wr_row_i  (row_cnt_q),
    .wr_data_i (in_row_i),
    .rd_t_i    (skew_cnt_q),
    .rd_data_o (rd_data),
    .rd_vld_o  (rd_vld)
  );

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    skew_cnt_d  = skew_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_vld_d   = '0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (row_cnt_q == ROW_LAST) begin
            row_cnt_d = '0;
            state_d   = ST_DRAIN;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // A stalled cycle emits nothing and leaves skew_cnt untouched.
        if (array_en_i) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_data;
          out_vld_d   = rd_vld;
          out_first_d = (skew_cnt_q == '0);
          out_last_d  = (skew_cnt_q == T_LAST);
          if (skew_cnt_q == T_LAST) begin
            skew_cnt_d = '0;
            state_d    = ST_LOAD;
          end else begin
            skew_cnt_d = skew_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      row_cnt_q   <= '0;
      skew_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_vld_q   <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      skew_cnt_q  <= skew_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_lane_vld_o = out_vld_q;
  assign out_first_o    = out_first_q;
  assign out_last_o     = out_last_q;
  assign tile_done_o    = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_tile_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_tile_feeder
//  Description : Scoreboard bench for matrix_tile_feeder. The driver pushes
//                the expected skewed beats of each tile when its last row is
//                accepted; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_tile_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int W  = N * DW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid_i = 1'b0;
  logic [W-1:0] in_row_i = '0;
  logic         array_en_i = 1'b1;
  logic         in_ready_o, out_valid_o, out_first_o, out_last_o;
  logic         tile_done_o, busy_o;
  logic [W-1:0] out_data_o;
  logic [N-1:0] out_lane_vld_o;

  matrix_tile_feeder #(.N(N), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_row_i       (in_row_i),
    .array_en_i     (array_en_i),
    .out_valid_o    (out_valid_o),
    .out_data_o     (out_data_o),
    .out_lane_vld_o (out_lane_vld_o),
    .out_first_o    (out_first_o),
    .out_last_o     (out_last_o),
    .tile_done_o    (tile_done_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic [N-1:0] mask;
    logic         first;
    logic         last;
  } beat_t;

  beat_t        sb_q[$];
  logic [DW-1:0] tile_m [N][N];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           first_cyc = 0;
  int           last_cyc = 0;
  int           en_mode = 0;
  logic         en_hold = 1'b1;
  logic         prev_last = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: skew step t shows A[i][t-i] on lane i whenever that column exists.
  function automatic void push_tile();
    for (int t = 0; t <= 2 * N - 2; t++) begin
      beat_t b;
      b = '0;
      for (int i = 0; i < N; i++) begin
        int j;
        j = t - i;
        if (j >= 0 && j < N) begin
          b.data[i*DW +: DW] = tile_m[i][j];
          b.mask[i] = 1'b1;
        end
      end
      b.first = (t == 0);
      b.last  = (t == 2 * N - 2);
      sb_q.push_back(b);
    end
  endfunction

  // Array-enable driver: scripted level or random stalls.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      array_en_i = (en_mode == 1) ? ($urandom_range(0, 3) != 0) : en_hold;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      if (prev_last) check("ready_after_last", {63'd0, in_ready_o}, 64'd1);
      if (out_valid_o) begin
        check("ready_low_in_drain", {63'd0, in_ready_o}, 64'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual data=%h mask=%b expected none", out_data_o, out_lane_vld_o);
        end else begin
          beat_t e;
          beat_t a;
          e = sb_q.pop_front();
          a = {out_data_o, out_lane_vld_o, out_first_o, out_last_o};
          check("beat", 64'(a), 64'(e));
          check("tile_done", {63'd0, tile_done_o}, {63'd0, e.last});
          check("busy_in_drain", {63'd0, busy_o}, {63'd0, sb_q.size() != 0});
          if (out_first_o) first_cyc = cyc;
          if (out_last_o) last_cyc = cyc;
        end
      end else begin
        check("idle_zero", 64'({out_data_o, out_lane_vld_o, out_first_o, out_last_o, tile_done_o}), 64'd0);
      end
      prev_last = out_last_o;
    end
  end

  // Present one row and hold it until the feeder takes it.
  task automatic send_row(input int r, input logic [W-1:0] row);
    int guard;
    guard = 0;
    in_valid_i = 1'b1;
    in_row_i   = row;
    while (!in_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual in_ready=0 expected 1 within 200 cycles");
    end
    for (int c = 0; c < N; c++) tile_m[r][c] = row[c*DW +: DW];
    if (r == N - 1) begin
      #1;
      push_tile();
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  // kind 0: A[r][c]=16r+c+off; kind 1: random. gap 0: none, 1: one cycle, 2: random.
  task automatic send_tile(input int kind, input logic [7:0] off, input int gap);
    for (int r = 0; r < N; r++) begin
      logic [W-1:0] row;
      for (int c = 0; c < N; c++)
        row[c*DW +: DW] = (kind == 0) ? 8'(16 * r + c) + off : 8'($urandom_range(0, 255));
      send_row(r, row);
      if (r != N - 1) begin
        int g;
        g = (gap == 2) ? $urandom_range(0, 2) : gap;
        repeat (g) @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb_q.size() != 0 || busy_o) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual pending=%0d expected 0", sb_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_ready", {63'd0, in_ready_o}, 64'd1);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_outs", 64'({out_valid_o, out_data_o, out_lane_vld_o, out_first_o, out_last_o, tile_done_o}), 64'd0);
    @(negedge clk);

    // Basic tile with directed spot values; first beat two negedges after accept.
    send_tile(0, 8'h00, 0);
    check("latency_no_early", {63'd0, out_valid_o}, 64'd0);
    @(negedge clk);
    check("t0_data", 64'(out_data_o), 64'h00000000);
    check("t0_mask_first", 64'({out_lane_vld_o, out_first_o}), 64'({4'b0001, 1'b1}));
    repeat (3) @(negedge clk);
    check("t3_data", 64'(out_data_o), 64'h30211203);
    check("t3_mask", 64'(out_lane_vld_o), 64'b1111);
    repeat (3) @(negedge clk);
    check("t6_data", 64'(out_data_o), 64'h33000000);
    check("t6_mask_last_done", 64'({out_lane_vld_o, out_last_o, tile_done_o}), 64'({4'b1000, 2'b11}));
    wait_idle();

    // Input gaps.
    send_tile(0, 8'h00, 1);
    wait_idle();
    check("gap_drain_len", 64'(last_cyc - first_cyc), 64'd6);

    // Two-cycle stall at t=2.
    send_tile(0, 8'h05, 0);
    @(negedge clk);
    @(negedge clk);
    en_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en_hold = 1'b1;
    wait_idle();
    check("stall_drain_len", 64'(last_cyc - first_cyc), 64'd8);

    // Back-to-back: second tile offered during the drain of the first.
    send_tile(0, 8'h00, 0);
    send_tile(0, 8'h80, 0);
    wait_idle();

    // Random data, gaps and stalls.
    en_mode = 1;
    for (int k = 0; k < 8; k++) begin
      send_tile(1, 8'h00, 2);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    en_mode = 0;
    @(negedge clk);

    // Reset mid-drain at t=3.
    send_tile(0, 8'h11, 0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("async_reset_outs", 64'({out_valid_o, out_data_o, out_lane_vld_o, out_first_o, out_last_o, tile_done_o}), 64'd0);
    check("async_reset_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready", {63'd0, in_ready_o}, 64'd1);
    @(negedge clk);
    send_tile(0, 8'h40, 0);
    wait_idle();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
